// File: rtl/parity_scrub_ctrl.sv
// Background parity scrubber. Walks every entry of a parity-protected array
// through a shared read port and gives way to functional traffic. It recomputes
// even parity for each entry and reports and counts mismatches.
module parity_scrub_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              abort,
  input  logic              func_busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic              rd_par,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mismatch;

  // State and scrub address registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and next-address selection; abort beats everything except start in IDLE.
  // NOTE: defaults first so no path leaves state_d/addr_d unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (!func_busy) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        addr_d = '0;
        if (abort || !cont_mode) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Moore outputs plus the read request, which is gated by func_busy so the
  // scrubber never contends with functional traffic.
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_ISSUE: begin
        busy  = 1'b1;
        rd_en = !func_busy;
      end
      S_CHECK: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_addr = addr_q;

  // An aborted check is discarded, so abort suppresses the mismatch outright.
  assign mismatch = (state_q == S_CHECK) && !abort && ((^rd_data) != rd_par);

  // Error reporting: one-cycle pulse, sticky last address, saturating counter
  // where a clear in the same cycle as an increment takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      err_valid <= mismatch;
      if (mismatch) begin
        err_addr <= addr_q;
      end
      if (clr_cnt) begin
        err_count <= '0;
      end else if (mismatch && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_scrub_ctrl.sv
// Self-checking bench for parity_scrub_ctrl: a small array model feeds the
// read port, and an abstract pass-level model predicts every output each cycle.
module tb_parity_scrub_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              cont_mode = 1'b0;
  logic              abort     = 1'b0;
  logic              func_busy = 1'b0;
  logic              clr_cnt   = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data   = '0;
  logic              rd_par    = 1'b0;
  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  err_count;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;

  parity_scrub_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cont_mode(cont_mode),
    .abort    (abort),
    .func_busy(func_busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_par   (rd_par),
    .err_valid(err_valid),
    .err_addr (err_addr),
    .err_count(err_count),
    .clr_cnt  (clr_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- storage array model ----------------
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_par  [DEPTH];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_data[rd_addr];
      rd_par  <= mem_par[rd_addr];
    end
  end

  task automatic fill_good();
    for (int i = 0; i < DEPTH; i++) begin
      mem_data[i] = WIDTH'(i * 37 + 11);
      mem_par[i]  = ^mem_data[i];
    end
  endtask

  // ---------------- pass-level reference model ----------------
  // m_active: a pass is in progress; m_next: next entry to read;
  // m_inflight: a read was granted last cycle and its result is due;
  // m_finish: all entries checked, completion is being reported this cycle.
  bit m_active = 0, m_inflight = 0, m_finish = 0, m_err_valid = 0;
  int m_next = 0, m_inflight_addr = 0, m_err_addr = 0, m_err_cnt = 0;

  task automatic model_reset();
    m_active = 0; m_inflight = 0; m_finish = 0; m_err_valid = 0;
    m_next = 0; m_inflight_addr = 0; m_err_addr = 0; m_err_cnt = 0;
  endtask

  task automatic model_step();
    bit ev;
    int ev_addr;
    ev = 0;
    ev_addr = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_next   = 0;
      end
    end else if (abort) begin
      m_active = 0; m_inflight = 0; m_finish = 0; m_next = 0;
    end else if (m_finish) begin
      m_finish = 0;
      m_next   = 0;
      if (!cont_mode) m_active = 0;
    end else if (m_inflight) begin
      m_inflight = 0;
      if ((^mem_data[m_inflight_addr]) != mem_par[m_inflight_addr]) begin
        ev = 1;
        ev_addr = m_inflight_addr;
      end
      if (m_inflight_addr == DEPTH - 1) m_finish = 1;
      else m_next = m_inflight_addr + 1;
    end else if (!func_busy) begin
      m_inflight = 1;
      m_inflight_addr = m_next;
    end
    m_err_valid = ev;
    if (ev) m_err_addr = ev_addr;
    if (clr_cnt) m_err_cnt = 0;
    else if (ev && m_err_cnt < CNT_MAX) m_err_cnt++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_rd_en;
    exp_rd_en = m_active && !m_inflight && !m_finish && !func_busy;
    check("busy", busy, m_active);
    check("rd_en", rd_en, exp_rd_en);
    if (exp_rd_en) check("rd_addr", rd_addr, m_next);
    check("done", done, m_finish);
    check("err_valid", err_valid, m_err_valid);
    check("err_addr", err_addr, m_err_addr);
    check("err_count", err_count, m_err_cnt);
  end

  // Observation counters for the hand-computed pass-level expectations.
  int busy_cycles = 0;
  int err_pulses  = 0;
  int rd_log[$];

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (err_valid) err_pulses++;
    if (rd_en) rd_log.push_back(int'(rd_addr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    busy_cycles = 0;
    err_pulses  = 0;
    rd_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_read(input int a, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (rd_en && (int'(rd_addr) == a)) found = 1;
    end
    check(name, found, 1);
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check(name, found, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    fill_good();
    #1;
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_err_valid", err_valid, 0);
    check("reset_done", done, 0);
    check("reset_err_addr", err_addr, 0);
    check("reset_err_count", err_count, 0);
    #12 reset = 1'b0;
    tick();

    // 1. Clean pass
    clear_obs();
    pulse_start();
    wait_done("t1_done_seen");
    tick();
    check("t1_busy_cycles", busy_cycles, 33);
    check("t1_err_pulses", err_pulses, 0);
    check("t1_err_count", err_count, 0);
    check("t1_reads", rd_log.size(), 16);
    for (int i = 0; i < rd_log.size() && i < DEPTH; i++) check("t1_rd_seq", rd_log[i], i);

    // 2. Single fault at entry 5; entry 6 has even data and correct parity
    mem_data[5] = 8'h01; mem_par[5] = 1'b0;
    mem_data[6] = 8'h03; mem_par[6] = 1'b0;
    clear_obs();
    pulse_start();
    wait_done("t2_done_seen");
    tick();
    check("t2_err_pulses", err_pulses, 1);
    check("t2_err_addr", err_addr, 5);
    check("t2_err_count", err_count, 1);
    check("t2_busy_cycles", busy_cycles, 33);

    // 3. Port contention: 7 stalled cycles at address 3
    fill_good();
    clear_obs();
    pulse_start();
    wait_read(2, "t3_read2_seen");
    tick();
    func_busy = 1'b1;
    repeat (8) tick();
    func_busy = 1'b0;
    wait_done("t3_done_seen");
    tick();
    check("t3_busy_cycles", busy_cycles, 40);
    check("t3_reads", rd_log.size(), 16);
    check("t3_err_count", err_count, 1);

    // 4. Saturation and clear-beats-increment, every entry corrupted
    for (int i = 0; i < DEPTH; i++) mem_par[i] = ~(^mem_data[i]);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t4_cleared", err_count, 0);
    clear_obs();
    pulse_start();
    wait_read(10, "t4_read10_seen");
    tick();
    check("t4_saturated", err_count, 3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t4_clr_wins", err_count, 0);
    check("t4_clr_err_valid", err_valid, 1);
    check("t4_clr_err_addr", err_addr, 10);
    wait_done("t4_done_seen");
    tick();
    check("t4_final_count", err_count, 3);
    check("t4_err_pulses", err_pulses, 16);

    // 5. Continuous mode, then abort in CHECK on a faulty entry
    fill_good();
    mem_par[9] = ~mem_par[9];
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    clear_obs();
    cont_mode = 1'b1;
    pulse_start();
    wait_done("t5_done_seen");
    @(negedge clk);
    check("t5_restart_rd_en", rd_en, 1);
    check("t5_restart_addr", rd_addr, 0);
    check("t5_restart_busy", busy, 1);
    wait_read(9, "t5_read9_seen");
    tick();
    abort = 1'b1;
    cont_mode = 1'b0;
    tick();
    abort = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_err_valid", err_valid, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_count", err_count, 1);
    repeat (3) tick();
    check("t5_err_pulses", err_pulses, 1);

    // 6. Asynchronous reset mid-pass
    fill_good();
    pulse_start();
    wait_read(4, "t6_read4_seen");
    check("t6_pre_count", err_count, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_rd_en", rd_en, 0);
    check("t6_async_count", err_count, 0);
    #1 reset = 1'b0;
    tick();
    clear_obs();
    pulse_start();
    wait_done("t6_done_seen");
    tick();
    check("t6_busy_cycles", busy_cycles, 33);
    check("t6_first_read", (rd_log.size() > 0) ? rd_log[0] : -1, 0);
    check("t6_err_count", err_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
